usb_transmitter: RTL and testbench

Full-speed-style USB serial transmitter. It is the transmit-side counterpart of the team's USB receiver datapath. Bytes are taken from an upstream source over a valid/ready handshake. The block prepends the SYNC byte, optionally bit-stuffs, NRZI-encodes LSB-first onto d_plus/d_minus, and terminates each packet with SE0-SE0-J (EOP). The packet length is the number of bytes offered back-to-back; a byte boundary with tx_valid low ends the packet.

---
 rtl/usb_pkg.sv | 26 ++
 rtl/tx_timer.sv | 33 +++
 rtl/usb_transmitter.sv | 169 ++++++++++++++++
 tb/tb_usb_transmitter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared types and constants for the USB transmit path.
// Line states are packed as {d_plus, d_minus}.
package usb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        STUFF,
        EOP1,
        EOP2,
        EOP_J
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'h80;
    localparam logic [1:0] LINE_J      = 2'b10;
    localparam logic [1:0] LINE_K      = 2'b01;
    localparam logic [1:0] LINE_SE0    = 2'b00;
    localparam int         STUFF_LIMIT = 6;

    // An NRZI level of 1 is J and 0 is K.
    function automatic logic [1:0] nrzi_line(input logic level);
        return level ? LINE_J : LINE_K;
    endfunction

endpackage

// File: rtl/tx_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled.
// pre_end flags the cycle before bit_end so that registered strobes can line up with it.
module tx_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic bit_end,
    output logic pre_end
);

    localparam int            W    = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0]  LAST = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0]  PRE  = W'(CLKS_PER_BIT - 2);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign bit_end = en && (count == LAST);
    assign pre_end = en && (count == PRE);

endmodule

// File: rtl/usb_transmitter.sv
// USB serial transmitter: SYNC, payload bytes LSB-first with optional bit stuffing,
// NRZI onto d_plus/d_minus, then SE0-SE0-J. All outputs are registered.
module usb_transmitter
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_EN     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       d_plus,
    output logic       d_minus,
    output logic       transmitting,
    output logic       tx_done,
    output tx_state_t  dbg_state
);

    // Handshake: a byte moves when tx_valid && tx_ready on a rising clk edge. tx_ready is a
    // one-cycle pulse on the last cycle of a byte's final bit period; tx_valid low there ends the packet.

    tx_state_t  state, state_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic [2:0] bit_idx, bit_idx_nxt;
    logic [2:0] ones, ones_nxt;
    logic       level, level_nxt;
    logic       last_stuff, last_stuff_nxt;
    logic [1:0] line, line_nxt;
    logic       ready_nxt, xmit_nxt, done_nxt;
    logic       bit_end, pre_end;
    logic       stuff_due, byte_end, take_byte;

    tx_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .en      (state != IDLE),
        .clr     (state == IDLE),
        .bit_end (bit_end),
        .pre_end (pre_end)
    );

    // The current bit is always shreg[0]; a sixth consecutive 1 forces a stuffed 0 next.
    assign stuff_due = (STUFF_EN != 0) && shreg[0] && (ones == 3'(STUFF_LIMIT - 1));
    assign byte_end  = ((state == SYNC || state == DATA) && bit_idx == 3'd7 && !stuff_due)
                     || (state == STUFF && last_stuff);

    always_comb begin
        state_nxt      = state;
        shreg_nxt      = shreg;
        bit_idx_nxt    = bit_idx;
        ones_nxt       = ones;
        level_nxt      = level;
        last_stuff_nxt = last_stuff;
        line_nxt       = line;
        xmit_nxt       = transmitting;
        done_nxt       = 1'b0;
        ready_nxt      = pre_end && byte_end;
        take_byte      = 1'b0;

        if (state == IDLE) begin
            line_nxt    = LINE_J;
            level_nxt   = 1'b1;
            ones_nxt    = 3'd0;
            bit_idx_nxt = 3'd0;
            xmit_nxt    = 1'b0;
            if (tx_start) begin
                state_nxt = SYNC;
                shreg_nxt = SYNC_BYTE;
                xmit_nxt  = 1'b1;
                level_nxt = SYNC_BYTE[0];
                line_nxt  = nrzi_line(SYNC_BYTE[0]);
            end
        end else if (bit_end) begin
            case (state)
                SYNC, DATA: begin
                    ones_nxt = shreg[0] ? ones + 3'd1 : 3'd0;
                    if (stuff_due) begin
                        state_nxt      = STUFF;
                        ones_nxt       = 3'd0;
                        last_stuff_nxt = (bit_idx == 3'd7);
                        shreg_nxt      = shreg >> 1;
                        bit_idx_nxt    = bit_idx + 3'd1;
                        level_nxt      = ~level;
                        line_nxt       = nrzi_line(~level);
                    end else if (bit_idx == 3'd7) begin
                        take_byte = 1'b1;
                    end else begin
                        shreg_nxt   = shreg >> 1;
                        bit_idx_nxt = bit_idx + 3'd1;
                        level_nxt   = shreg[1] ? level : ~level;
                        line_nxt    = nrzi_line(shreg[1] ? level : ~level);
                    end
                end
                STUFF: begin
                    if (last_stuff) begin
                        take_byte = 1'b1;
                    end else begin
                        state_nxt = DATA;
                        level_nxt = shreg[0] ? level : ~level;
                        line_nxt  = nrzi_line(shreg[0] ? level : ~level);
                    end
                end
                EOP1: begin
                    state_nxt = EOP2;
                    line_nxt  = LINE_SE0;
                end
                EOP2: begin
                    state_nxt = EOP_J;
                    line_nxt  = LINE_J;
                    level_nxt = 1'b1;
                end
                EOP_J: begin
                    state_nxt = IDLE;
                    line_nxt  = LINE_J;
                    xmit_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase

            if (take_byte) begin
                if (tx_valid) begin
                    state_nxt   = DATA;
                    shreg_nxt   = tx_data;
                    bit_idx_nxt = 3'd0;
                    level_nxt   = tx_data[0] ? level : ~level;
                    line_nxt    = nrzi_line(tx_data[0] ? level : ~level);
                end else begin
                    state_nxt = EOP1;
                    line_nxt  = LINE_SE0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            shreg        <= 8'h00;
            bit_idx      <= 3'd0;
            ones         <= 3'd0;
            level        <= 1'b1;
            last_stuff   <= 1'b0;
            line         <= LINE_J;
            tx_ready     <= 1'b0;
            transmitting <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            state        <= state_nxt;
            shreg        <= shreg_nxt;
            bit_idx      <= bit_idx_nxt;
            ones         <= ones_nxt;
            level        <= level_nxt;
            last_stuff   <= last_stuff_nxt;
            line         <= line_nxt;
            tx_ready     <= ready_nxt;
            transmitting <= xmit_nxt;
            tx_done      <= done_nxt;
        end
    end

    assign d_plus    = line[1];
    assign d_minus   = line[0];
    assign dbg_state = state;

endmodule

// File: tb/tb_usb_transmitter.sv
// Self-checking bench for usb_transmitter: one instance without stuffing, one with,
// compared cycle by cycle against a bit-stream reference model.
module tb_usb_transmitter;
    import usb_pkg::*;

    localparam int         CPB  = 8;
    localparam logic [1:0] L_J  = 2'b10;
    localparam logic [1:0] L_K  = 2'b01;
    localparam logic [1:0] L_SE = 2'b00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] tx_start = '0;
    logic [1:0] tx_valid = '0;
    logic [7:0] tx_data [2];
    logic [1:0] tx_ready, d_plus, d_minus, transmitting, tx_done;
    tx_state_t  dbg_state [2];

    int checks   = 0;
    int failures = 0;

    logic [1:0] exp_q[$];
    int         ready_q[$];
    int         hs_cyc_q[$];
    logic       dp_q[$];

    always #5 clk = ~clk;

    usb_transmitter #(.CLKS_PER_BIT(CPB), .STUFF_EN(0)) dut0 (
        .clk(clk), .rst(rst), .tx_start(tx_start[0]), .tx_data(tx_data[0]),
        .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .d_plus(d_plus[0]),
        .d_minus(d_minus[0]), .transmitting(transmitting[0]), .tx_done(tx_done[0]),
        .dbg_state(dbg_state[0])
    );

    usb_transmitter #(.CLKS_PER_BIT(CPB), .STUFF_EN(1)) dut1 (
        .clk(clk), .rst(rst), .tx_start(tx_start[1]), .tx_data(tx_data[1]),
        .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .d_plus(d_plus[1]),
        .d_minus(d_minus[1]), .transmitting(transmitting[1]), .tx_done(tx_done[1]),
        .dbg_state(dbg_state[1])
    );

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_reset(input int s, input string tag);
        check({tag, " d_plus"}, 32'(d_plus[s]), 1);
        check({tag, " d_minus"}, 32'(d_minus[s]), 0);
        check({tag, " tx_ready"}, 32'(tx_ready[s]), 0);
        check({tag, " transmitting"}, 32'(transmitting[s]), 0);
        check({tag, " tx_done"}, 32'(tx_done[s]), 0);
        check({tag, " state_idle"}, 32'(dbg_state[s]), 32'(IDLE));
    endtask

    // Reference: wire bit list (SYNC + bytes, stuffed 0 after six 1s), NRZI levels, then EOP.
    task automatic build_model(input int stuff, input logic [7:0] bytes[$]);
        int         ones;
        logic       lvl;
        logic       b_q[$];
        logic [7:0] v;
        ones = 0;
        lvl  = 1'b1;
        exp_q.delete();
        ready_q.delete();
        for (int k = 0; k <= bytes.size(); k++) begin
            v = (k == 0) ? 8'h80 : bytes[k-1];
            for (int i = 0; i < 8; i++) begin
                b_q.push_back(v[i]);
                ones = v[i] ? ones + 1 : 0;
                if (stuff != 0 && ones == 6) begin
                    b_q.push_back(1'b0);
                    ones = 0;
                end
            end
            ready_q.push_back(b_q.size() - 1);
        end
        foreach (b_q[i]) begin
            if (!b_q[i]) lvl = ~lvl;
            exp_q.push_back(lvl ? L_J : L_K);
        end
        exp_q.push_back(L_SE);
        exp_q.push_back(L_SE);
        exp_q.push_back(L_J);
    endtask

    // Entered at a negedge with the DUT idle; returns at the negedge where tx_done is seen.
    task automatic run_packet(input int s, input logic [7:0] bytes[$], input bit mid_pulse,
                              input bit final_pulse, input string name,
                              output int hs_n, output int last_ready);
        int   total, nxt, bad_line, bad_ready, done_cyc, p;
        bit   hs_pend, exp_r;
        build_model(s, bytes);
        total = exp_q.size() * CPB;
        hs_cyc_q.delete();
        dp_q.delete();
        tx_start[s] = 1'b1;
        tx_valid[s] = (bytes.size() > 0);
        tx_data[s]  = (bytes.size() > 0) ? bytes[0] : 8'($urandom);
        @(negedge clk);
        tx_start[s] = 1'b0;
        nxt = 1; hs_n = 0; last_ready = -1; done_cyc = -1;
        bad_line = 0; bad_ready = 0; hs_pend = 0;
        for (int cyc = 0; cyc < total + 2 * CPB && done_cyc < 0; cyc++) begin
            if (hs_pend) begin
                hs_pend = 0;
                if (nxt < bytes.size()) begin
                    tx_data[s] = bytes[nxt];
                    nxt++;
                end else begin
                    tx_valid[s] = 1'b0;
                    tx_data[s]  = 8'($urandom);
                end
            end
            if (tx_done[s]) begin
                done_cyc = cyc;
            end else begin
                p = cyc / CPB;
                exp_r = 0;
                foreach (ready_q[i]) if (ready_q[i] == p && cyc % CPB == CPB - 1) exp_r = 1;
                if (cyc >= total || {d_plus[s], d_minus[s]} !== exp_q[p] || transmitting[s] !== 1'b1)
                    bad_line++;
                if (tx_ready[s] !== exp_r) bad_ready++;
                if (cyc % CPB == CPB / 2) dp_q.push_back(d_plus[s]);
                if (tx_ready[s]) last_ready = cyc;
                if (tx_ready[s] && tx_valid[s]) begin
                    hs_n++;
                    hs_pend = 1;
                    hs_cyc_q.push_back(cyc);
                end
                if (mid_pulse && cyc == 100) tx_start[s] = 1'b1;
                if (mid_pulse && cyc == 101) tx_start[s] = 1'b0;
                if (final_pulse && cyc == total - 1) tx_start[s] = 1'b1;
                @(negedge clk);
            end
        end
        tx_start[s] = 1'b0;
        check({name, " line_err_cycles"}, bad_line, 0);
        check({name, " ready_err_cycles"}, bad_ready, 0);
        check({name, " done_cycle"}, done_cyc, total);
        check({name, " done_idle_line"}, {30'd0, d_plus[s], d_minus[s]}, 32'(L_J));
        check({name, " done_not_transmitting"}, 32'(transmitting[s]), 0);
        check({name, " handshakes"}, hs_n, bytes.size());
    endtask

    typedef struct {
        int         s;
        int         n;
        logic [7:0] b0, b1, b2;
        int         exp_bits;
        int         exp_last_ready;
        bit         mid_pulse;
        bit         final_pulse;
    } vec_t;

    initial begin
        vec_t       vecs[5];
        logic [7:0] bq[$];
        logic [18:0] a5_dp;
        logic [18:0] got_dp;
        int         hs_n, last_ready;

        vecs[0] = '{0, 1, 8'hA5, 8'h00, 8'h00, 19, 127, 1'b0, 1'b1};
        vecs[1] = '{0, 0, 8'h00, 8'h00, 8'h00, 11, 63,  1'b0, 1'b0};
        vecs[2] = '{0, 3, 8'h00, 8'hFF, 8'h3C, 35, 255, 1'b1, 1'b0};
        vecs[3] = '{1, 1, 8'hFF, 8'h00, 8'h00, 20, 135, 1'b0, 1'b0};
        vecs[4] = '{1, 3, 8'h00, 8'hFF, 8'h3C, 36, 263, 1'b1, 1'b0};
        a5_dp   = 19'b0101010001101100001;
        tx_data[0] = 8'h00;
        tx_data[1] = 8'h00;

        repeat (2) @(negedge clk);
        check_reset(0, "reset0");
        check_reset(1, "reset1");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        rst = 1'b1;
        #1;
        check_reset(0, "idle_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            bq.delete();
            if (vecs[v].n > 0) bq.push_back(vecs[v].b0);
            if (vecs[v].n > 1) bq.push_back(vecs[v].b1);
            if (vecs[v].n > 2) bq.push_back(vecs[v].b2);
            run_packet(vecs[v].s, bq, vecs[v].mid_pulse, vecs[v].final_pulse,
                       $sformatf("vec%0d", v), hs_n, last_ready);
            check($sformatf("vec%0d model_bits", v), exp_q.size(), vecs[v].exp_bits);
            check($sformatf("vec%0d last_ready_cycle", v), last_ready, vecs[v].exp_last_ready);
            if (v == 0) begin
                got_dp = '0;
                foreach (dp_q[i]) got_dp = {got_dp[17:0], dp_q[i]};
                check("a5 d_plus_pattern", {13'd0, got_dp}, {13'd0, a5_dp});
            end
            if (v == 2) begin
                if (hs_cyc_q.size() == 3) begin
                    check("b2b hs_spacing_1", hs_cyc_q[1] - hs_cyc_q[0], 64);
                    check("b2b hs_spacing_2", hs_cyc_q[2] - hs_cyc_q[1], 64);
                end else begin
                    check("b2b hs_count", hs_cyc_q.size(), 3);
                end
            end
        end
        @(negedge clk);

        // Abort in the middle of a data byte: the line must snap to J before any clock edge.
        tx_start[0] = 1'b1;
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'h00;
        @(negedge clk);
        tx_start[0] = 1'b0;
        repeat (92) @(negedge clk);
        check("pre_reset d_plus_k", 32'(d_plus[0]), 0);
        check("pre_reset transmitting", 32'(transmitting[0]), 1);
        rst = 1'b1;
        #1;
        check_reset(0, "data_reset");
        @(negedge clk);
        rst = 1'b0;
        tx_valid[0] = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 12; r++) begin
            int s, n;
            s = $urandom_range(0, 1);
            n = $urandom_range(0, 3);
            bq.delete();
            for (int k = 0; k < n; k++)
                bq.push_back($urandom_range(0, 1) ? 8'hFF : 8'($urandom));
            run_packet(s, bq, 1'b0, 1'b0, $sformatf("rand%0d", r), hs_n, last_ready);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
